serial_subtractor: RTL and testbench

Bit-serial, multi-cycle unsigned subtractor: the inverse-direction companion to the combinational ripple-carry adder datapath. It computes `a - b - bin` one bit per clock through a single full-subtractor cell, with the borrow held in a flop between bits. It trades latency for area. Operands enter through a start/ready handshake, and the result is announced with a one-cycle `done` pulse.

---
 rtl/serial_subtractor_pkg.sv | 12 +
 rtl/serial_subtractor_fs.sv | 13 +
 rtl/serial_subtractor.sv | 108 ++++++++++
 tb/tb_serial_subtractor.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared arithmetic definitions for the serial subtractor datapath.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  localparam int SUB_MIN_WIDTH = 2;

endpackage

// File: rtl/serial_subtractor_fs.sv
// One-bit full subtractor cell: d = x - y - bi, with borrow-out bo.
module fs (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~x & bi) | (y & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes (a - b - bin) one bit per clock
// through a single full-subtractor cell, LSB first, with a start/ready
// handshake and a one-cycle done pulse when diff/bout are updated.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  if (WIDTH < SUB_MIN_WIDTH || WIDTH > 32) begin : g_bad_width
    $fatal(1, "serial_subtractor: WIDTH must be in 2..32");
  end

  sub_state_t       state_q;
  sub_state_t       state_d;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  // Result bits collected so far; the final bit goes straight into diff.
  logic [WIDTH-2:0] r_sr;
  logic [WIDTH-1:0] r_next;
  logic             brw_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             d_bit;
  logic             bo_bit;
  logic             last_bit;

  fs u_fs (
    .x  (a_sr[0]),
    .y  (b_sr[0]),
    .bi (brw_q),
    .d  (d_bit),
    .bo (bo_bit)
  );

  assign last_bit = (cnt_q == CW'(WIDTH - 1));
  assign r_next   = {d_bit, r_sr};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode: RUN lasts exactly WIDTH cycles, DONE exactly one.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Serial datapath: load on accept, then shift one bit per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr  <= '0;
      b_sr  <= '0;
      r_sr  <= '0;
      brw_q <= 1'b0;
      cnt_q <= '0;
    end else if (state_q == IDLE && start) begin
      a_sr  <= a;
      b_sr  <= b;
      brw_q <= bin;
      cnt_q <= '0;
    end else if (state_q == RUN) begin
      a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
      r_sr  <= r_next[WIDTH-1:1];
      brw_q <= bo_bit;
      if (!last_bit) cnt_q <= cnt_q + 1'b1;
    end
  end

  // Output registers: updated only on the final bit, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q <= '0;
      bout_q <= 1'b0;
    end else if (state_q == RUN && last_bit) begin
      diff_q <= r_next;
      bout_q <= bo_bit;
    end
  end

  assign diff  = diff_q;
  assign bout  = bout_q;
  assign ready = (state_q == IDLE);
  assign done  = (state_q == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized checks of serial_subtractor at WIDTH=4 and WIDTH=8.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       st4, bin4, rdy4, done4, bout4;
  logic [3:0] a4, b4, diff4;
  logic       st8, bin8, rdy8, done8, bout8;
  logic [7:0] a8, b8, diff8;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(4)) u4 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (st4),
    .a     (a4),
    .b     (b4),
    .bin   (bin4),
    .ready (rdy4),
    .diff  (diff4),
    .bout  (bout4),
    .done  (done4)
  );

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (st8),
    .a     (a8),
    .b     (b8),
    .bin   (bin8),
    .ready (rdy8),
    .diff  (diff8),
    .bout  (bout8),
    .done  (done8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic get_done(input int w);
    return (w == 4) ? done4 : done8;
  endfunction

  function automatic logic get_ready(input int w);
    return (w == 4) ? rdy4 : rdy8;
  endfunction

  function automatic logic get_bout(input int w);
    return (w == 4) ? bout4 : bout8;
  endfunction

  function automatic logic [31:0] get_diff(input int w);
    return (w == 4) ? {28'd0, diff4} : {24'd0, diff8};
  endfunction

  task automatic drive(input int w, input logic s, input logic [31:0] a,
                       input logic [31:0] b, input logic bi);
    if (w == 4) begin
      st4 = s; a4 = a[3:0]; b4 = b[3:0]; bin4 = bi;
    end else begin
      st8 = s; a8 = a[7:0]; b8 = b[7:0]; bin8 = bi;
    end
  endtask

  // One full transaction checked against plain-arithmetic expectations.
  task automatic do_op(input int w, input logic [31:0] a, input logic [31:0] b,
                       input logic bi, input string tag);
    longint     r;
    logic [31:0] exp_diff;
    logic        exp_bout;
    int          k;
    bit          got;
    bit          rdy_seen;
    r        = longint'(a) - longint'(b) - longint'(bi);
    exp_diff = 32'(r & ((64'd1 << w) - 1));
    exp_bout = (r < 0);
    @(negedge clk);
    drive(w, 1'b1, a, b, bi);
    @(posedge clk); #1;
    // Scramble operands after acceptance; they must not matter.
    drive(w, 1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)));
    k = 0; got = 0; rdy_seen = 0;
    while (!got && k < w + 4) begin
      @(posedge clk); #1;
      k++;
      if (get_ready(w)) rdy_seen = 1;
      if (get_done(w)) got = 1;
    end
    chk({tag, " done_seen"}, 64'(got), 64'd1);
    chk({tag, " latency"}, 64'(k), 64'(w));
    chk({tag, " ready_low_busy"}, 64'(rdy_seen), 64'd0);
    chk({tag, " diff"}, 64'(get_diff(w)), 64'(exp_diff));
    chk({tag, " bout"}, 64'(get_bout(w)), 64'(exp_bout));
    @(posedge clk); #1;
    chk({tag, " done_one_cycle"}, 64'(get_done(w)), 64'd0);
    chk({tag, " ready_back"}, 64'(get_ready(w)), 64'd1);
  endtask

  initial begin
    int  k, c, nd, t1, t2;
    bit  got;
    logic [31:0] ra, rb;
    logic        rbi;

    // Reset state
    rst_n = 1'b0;
    drive(4, 1'b0, 0, 0, 1'b0);
    drive(8, 1'b0, 0, 0, 1'b0);
    #12;
    chk("rst ready4", 64'(rdy4), 64'd1);
    chk("rst done4", 64'(done4), 64'd0);
    chk("rst diff4", 64'(diff4), 64'd0);
    chk("rst bout4", 64'(bout4), 64'd0);
    chk("rst ready8", 64'(rdy8), 64'd1);
    chk("rst diff8", 64'(diff8), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic and boundary cases
    do_op(4, 9, 3, 1'b0, "w4 9-3");
    do_op(4, 3, 9, 1'b0, "w4 3-9");
    do_op(4, 0, 0, 1'b1, "w4 0-0-1");
    do_op(4, 15, 15, 1'b0, "w4 15-15");
    do_op(4, 15, 0, 1'b1, "w4 15-0-1");
    do_op(8, 200, 57, 1'b0, "w8 200-57");
    do_op(8, 0, 255, 1'b1, "w8 0-255-1");
    do_op(8, 128, 127, 1'b1, "w8 128-127-1");

    // Start ignored while busy
    @(negedge clk);
    drive(4, 1'b1, 9, 3, 1'b0);
    @(posedge clk); #1;
    a4 = 4'd1; b4 = 4'd2;
    k = 0; got = 0;
    while (!got && k < 10) begin
      @(posedge clk); #1;
      k++;
      if (done4) got = 1;
    end
    st4 = 1'b0;
    chk("busy done_seen", 64'(got), 64'd1);
    chk("busy latency", 64'(k), 64'd4);
    chk("busy diff", 64'(diff4), 64'd6);
    chk("busy bout", 64'(bout4), 64'd0);
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done4) nd++;
    end
    chk("busy no_second_done", 64'(nd), 64'd0);
    chk("busy diff_held", 64'(diff4), 64'd6);

    // Reset mid-operation (during bit 2)
    @(negedge clk);
    drive(4, 1'b1, 9, 3, 1'b0);
    @(posedge clk); #1;
    st4 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst diff", 64'(diff4), 64'd0);
    chk("midrst bout", 64'(bout4), 64'd0);
    chk("midrst done", 64'(done4), 64'd0);
    chk("midrst ready", 64'(rdy4), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done4) nd++;
    end
    chk("midrst no_done", 64'(nd), 64'd0);
    do_op(4, 7, 2, 1'b0, "w4 7-2 after rst");

    // Back-to-back with start held high, WIDTH=8
    @(negedge clk);
    drive(8, 1'b1, 200, 57, 1'b0);
    c = 0; nd = 0; t1 = 0; t2 = 0;
    while (nd < 2 && c < 40) begin
      @(posedge clk); #1;
      c++;
      if (done8) begin
        nd++;
        if (nd == 1) begin
          t1 = c;
          chk("b2b diff1", 64'(diff8), 64'd143);
          chk("b2b bout1", 64'(bout8), 64'd0);
          a8 = 8'd57; b8 = 8'd200;
        end else begin
          t2 = c;
          chk("b2b diff2", 64'(diff8), 64'd113);
          chk("b2b bout2", 64'(bout8), 64'd1);
        end
      end
    end
    st8 = 1'b0;
    chk("b2b two_dones", 64'(nd), 64'd2);
    chk("b2b first_at", 64'(t1), 64'd9);
    chk("b2b spacing", 64'(t2 - t1), 64'd10);

    // Random compare
    for (int i = 0; i < 500; i++) begin
      ra  = 32'($urandom_range(0, 15));
      rb  = 32'($urandom_range(0, 15));
      rbi = 1'($urandom_range(0, 1));
      do_op(4, ra, rb, rbi, "rnd w4");
    end
    for (int i = 0; i < 500; i++) begin
      ra  = 32'($urandom_range(0, 255));
      rb  = 32'($urandom_range(0, 255));
      rbi = 1'($urandom_range(0, 1));
      do_op(8, ra, rb, rbi, "rnd w8");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
